// File: rtl/pipe_scroller.sv
// pipe_scroller: moves a single pipe obstacle leftward once per frame tick,
// respawns it off-screen right with a freshly requested gap height, and
// counts passes of the bird column with a saturating score.
//
// state  | meaning
// IDLE   | no game running; outputs hold until start
// WAIT_H | height_req raised, waiting for the height generator
// RUN    | pipe visible and scrolling on each frame tick
module pipe_scroller #(
    parameter int START_X = 700,
    parameter int START_Y = 200,
    parameter int SPEED   = 2,
    parameter int PIPE_W  = 60,
    parameter int BIRD_X  = 150,
    parameter int GAP_MIN = 65,
    parameter int GAP_MAX = 464
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] height_in,
    input  logic       height_valid,
    output logic       height_req,
    output logic [9:0] pipe_x,
    output logic [9:0] gap_y,
    output logic       visible,
    output logic       pass_pulse,
    output logic [7:0] score
);

    typedef enum logic [1:0] {IDLE, WAIT_H, RUN} state_t;

    localparam logic [9:0]  START_X_V = 10'(START_X);
    localparam logic [9:0]  START_Y_V = 10'(START_Y);
    localparam logic [9:0]  SPEED_V   = 10'(SPEED);
    localparam logic [9:0]  GAP_MIN_V = 10'(GAP_MIN);
    localparam logic [9:0]  GAP_MAX_V = 10'(GAP_MAX);
    localparam logic [10:0] SPEED_E   = 11'(SPEED);
    localparam logic [10:0] PIPE_W_E  = 11'(PIPE_W);
    localparam logic [10:0] BIRD_X_E  = 11'(BIRD_X);

    state_t state, state_nxt;

    logic [9:0]  pipe_x_nxt, gap_y_nxt, gap_clamped;
    logic        visible_nxt, req_nxt, pass_nxt;
    logic [7:0]  score_nxt;
    logic [10:0] edge_old, edge_new;
    logic        wrap, pass_hit;

    // Right edge before and after a step, widened so neither add nor subtract wraps.
    assign edge_old = {1'b0, pipe_x} + PIPE_W_E;
    assign edge_new = edge_old - SPEED_E;
    assign wrap     = {1'b0, pipe_x} < SPEED_E;
    assign pass_hit = (edge_old >= BIRD_X_E) && (edge_new < BIRD_X_E);

    // Clamp the incoming height into the playable gap range.
    always_comb begin
        gap_clamped = height_in;
        if (height_in < GAP_MIN_V)
            gap_clamped = GAP_MIN_V;
        else if (height_in > GAP_MAX_V)
            gap_clamped = GAP_MAX_V;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state selection; stop always wins over every other event.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = WAIT_H;
            WAIT_H:  if (stop) state_nxt = IDLE;
                     else if (height_valid) state_nxt = RUN;
            RUN:     if (stop) state_nxt = IDLE;
                     else if (frame_tick && wrap) state_nxt = WAIT_H;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        pipe_x_nxt  = pipe_x;
        gap_y_nxt   = gap_y;
        visible_nxt = visible;
        req_nxt     = height_req;
        pass_nxt    = 1'b0;
        score_nxt   = score;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    pipe_x_nxt  = START_X_V;
                    score_nxt   = 8'd0;
                    visible_nxt = 1'b0;
                    req_nxt     = 1'b1;
                end
            end
            WAIT_H: begin
                if (stop) begin
                    req_nxt = 1'b0;
                end else if (height_valid) begin
                    gap_y_nxt   = gap_clamped;
                    visible_nxt = 1'b1;
                    req_nxt     = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    req_nxt = 1'b0;
                end else if (frame_tick) begin
                    if (wrap) begin
                        pipe_x_nxt  = START_X_V;
                        visible_nxt = 1'b0;
                        req_nxt     = 1'b1;
                    end else begin
                        pipe_x_nxt = pipe_x - SPEED_V;
                        if (pass_hit) begin
                            pass_nxt = 1'b1;
                            if (score != 8'hFF)
                                score_nxt = score + 8'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_x     <= START_X_V;
            gap_y      <= START_Y_V;
            visible    <= 1'b0;
            height_req <= 1'b0;
            pass_pulse <= 1'b0;
            score      <= 8'd0;
        end else begin
            pipe_x     <= pipe_x_nxt;
            gap_y      <= gap_y_nxt;
            visible    <= visible_nxt;
            height_req <= req_nxt;
            pass_pulse <= pass_nxt;
            score      <= score_nxt;
        end
    end

endmodule
